// File: rtl/div_sequencer_if.sv
// Handshake and result bundle for the iterative divider.
// The requester drives start/op/a/b/kill; the divider returns busy/done/result/stall.
interface div_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            stall;

    modport master (
        output start, op, a, b, kill,
        input  busy, done, result, stall
    );

    modport slave (
        input  start, op, a, b, kill,
        output busy, done, result, stall
    );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider: DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow skip the iteration and finish in one cycle.
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    div_sequencer_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] quo_q;     // dividend magnitude, shifted out as quotient shifts in
    logic [XLEN-1:0] dvs_q;     // divisor magnitude
    logic [XLEN-1:0] rem_q;     // partial remainder
    logic [XLEN-1:0] result_q;
    logic [CW-1:0]   cnt_q;

    // Request qualification on the live inputs
    logic            can_start;
    logic            accept;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_res;

    assign can_start = (state_q == IDLE) || (state_q == DONE);
    assign accept    = bus.start && can_start && !bus.kill;
    assign div_zero  = (bus.b == '0);
    assign overflow  = !bus.op[0] && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
    assign special   = div_zero || overflow;
    // Zero divisor: quotient all ones, remainder is the dividend.
    // Overflow: quotient is the dividend (most negative value), remainder 0.
    assign special_res = div_zero ? (bus.op[1] ? bus.a : '1)
                                  : (bus.op[1] ? '0 : bus.a);

    // Sign handling on the captured operands
    logic            signed_op;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [XLEN-1:0] fixed_res;

    assign signed_op = !op_q[0];
    assign neg_q     = signed_op && (a_q[XLEN-1] ^ b_q[XLEN-1]);
    assign neg_r     = signed_op && a_q[XLEN-1];
    assign a_abs     = (signed_op && a_q[XLEN-1]) ? -a_q : a_q;
    assign b_abs     = (signed_op && b_q[XLEN-1]) ? -b_q : b_q;
    assign fixed_res = op_q[1] ? (neg_r ? -rem_q : rem_q)
                               : (neg_q ? -quo_q : quo_q);

    // One restoring step: bring in the next dividend bit and try to subtract.
    // Bit XLEN of the difference is the borrow, i.e. "divisor did not fit".
    logic [XLEN:0] rem_shift;
    logic [XLEN:0] diff;

    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign diff      = rem_shift - {1'b0, dvs_q};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state decode; kill overrides every transition
    always_comb begin
        // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: state_d = accept ? (special ? DONE : PREP) : IDLE;
            PREP:       state_d = CALC;
            CALC:       state_d = (cnt_q == CW'(1)) ? FIX : CALC;
            FIX:        state_d = DONE;
            default:    state_d = IDLE;
        endcase
        if (bus.kill) state_d = IDLE;
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                op_q <= bus.op;
                a_q  <= bus.a;
                b_q  <= bus.b;
                if (special) result_q <= special_res;
            end
            unique case (state_q)
                PREP: begin
                    quo_q <= a_abs;
                    dvs_q <= b_abs;
                    rem_q <= '0;
                    cnt_q <= CW'(XLEN);
                end
                CALC: begin
                    rem_q <= diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
                    cnt_q <= cnt_q - CW'(1);
                end
                FIX: begin
                    // An aborted operation must leave the previous result visible.
                    if (!bus.kill) result_q <= fixed_res;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state_q == PREP) || (state_q == CALC) || (state_q == FIX);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.stall  = bus.busy || (accept && !special);

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; only 32 is required to be supported.
REQ-002 clk  input  1  rising-edge system clock; the only clock.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled on rising clk only when state is IDLE or DONE.
REQ-005 op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; captured at accepted start.
REQ-006 a  input  32  dividend; captured at accepted start.
REQ-007 b  input  32  divisor; captured at accepted start.
REQ-008 kill  input  1  pipeline flush; aborts any operation in progress.
REQ-009 busy  output  1  high in PREP, CALC, FIX.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 result  output  32  quotient or remainder per captured op.
REQ-012 stall  output  1  combinational: busy OR (start AND state in {IDLE, DONE} AND NOT kill AND operation not special-case).

Function
REQ-013 States SHALL be IDLE, PREP, CALC, FIX, DONE; no other state is reachable.
REQ-014 Start accepted (IDLE or DONE, kill low) SHALL register op/a/b and go to PREP, or to DONE for special cases (REQ-020, REQ-021).
REQ-015 PREP SHALL form |a|, |b| for DIV/REM (two's complement), raw values for DIVU/REMU, clear the 32-bit partial remainder, and load a 6-bit counter with 32.
REQ-016 CALC SHALL perform one restoring shift-subtract step per cycle (quotient bit MSB first), decrement the counter, and go to FIX after the counter reaches 0 (exactly 32 CALC cycles).
REQ-017 FIX SHALL negate the quotient if signed op and sign(a) != sign(b); negate the remainder if signed op and a negative; then go to DONE.
REQ-018 DONE SHALL assert done for exactly one cycle, then go to IDLE unless a new start is accepted in that cycle.
REQ-019 Normal latency: start sampled at edge T0 -> done high in cycle T0+35 (PREP 1, CALC 32, FIX 1).
REQ-020 Divide by zero (b = 0) SHALL bypass to DONE: done in cycle T0+1; DIV/DIVU result 0xFFFFFFFF; REM/REMU result a.
REQ-021 Signed overflow (op DIV or REM, a = 0x80000000, b = 0xFFFFFFFF) SHALL bypass to DONE: DIV result 0x80000000, REM result 0.
REQ-022 result SHALL hold its value from the DONE cycle until the next done pulse; it is not updated by an aborted operation.
REQ-023 start while busy SHALL be ignored with no effect on state or captured operands.
REQ-024 kill high at any edge SHALL force IDLE with no done pulse; kill and start in the same cycle: kill wins and start is dropped.
REQ-025 Unsigned compare/subtract SHALL use a 33-bit difference; all arithmetic is modulo 2^32.

Reset
REQ-026 rst low SHALL immediately set state IDLE, busy 0, done 0, result 0x00000000, counter 0, and all operand registers 0, regardless of clk.
REQ-027 rst asserted mid-operation SHALL abort without a done pulse; after deassertion the first accepted start SHALL behave as from a clean reset.

Verification
REQ-028 DIVU a=100, b=7 -> done exactly at T0+35, result 14; REMU same operands -> result 2.
REQ-029 DIV a=-7 (0xFFFFFFF9), b=2 -> result 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1).
REQ-030 DIV a=5, b=0 -> done at T0+1, result 0xFFFFFFFF, stall low; REMU a=5, b=0 -> result 5.
REQ-031 DIV a=0x80000000, b=0xFFFFFFFF -> done at T0+1, result 0x80000000; REM -> 0.
REQ-032 Start DIVU 100/7, kill at T0+10 -> busy low at next edge, no done pulse, result unchanged; new start then completes normally.
REQ-033 Back-to-back: start held high through DONE cycle with new operands 9/3 DIVU -> second done at its T0+35, result 3; start pulses during busy are ignored.
